// File: rtl/phase_sequencer.sv
// phase_sequencer: N-phase cyclic sequencer with pause/restart, per-phase dwell and loop counter.
// Optional PHASE_SEQ_ONESHOT_EN adds oneshot/done to stop in the last phase after one loop.
module phase_sequencer #(
    parameter int NUM_PHASES = 3,
    parameter int PW         = $clog2(NUM_PHASES),
    parameter int DWELL_W    = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pause,
    input  logic                          restart,
`ifdef PHASE_SEQ_ONESHOT_EN
    input  logic                          oneshot,
    output logic                          done,
`endif
    input  logic [NUM_PHASES*DWELL_W-1:0] dwell,
    output logic [PW-1:0]                 phase,
    output logic                          odd,
    output logic                          even,
    output logic                          terminal,
    output logic [CNT_W-1:0]              loop_cnt
);
    logic [PW-1:0]      r_phase;
    logic [DWELL_W-1:0] r_dc;
    logic [CNT_W-1:0]   r_cnt;
    logic [DWELL_W-1:0] w_dw;
    logic               w_inr;
    logic               w_last;
    logic               w_done;
    logic               w_hold;

`ifdef PHASE_SEQ_ONESHOT_EN
    logic r_done;
    assign done   = r_done;
    assign w_hold = r_done;
`else
    assign w_hold = 1'b0;
`endif

    assign w_inr  = int'(r_phase) < NUM_PHASES;
    assign w_last = int'(r_phase) == NUM_PHASES - 1;
    // Out-of-range phases read a zero dwell; they are flushed to phase 0 anyway.
    assign w_dw   = w_inr ? dwell[int'(r_phase)*DWELL_W +: DWELL_W] : '0;
    assign w_done = r_dc >= w_dw;

    assign phase    = r_phase;
    assign loop_cnt = r_cnt;
    assign odd      = ~r_phase[0];
    assign even     = r_phase[0];
    assign terminal = w_hold ? restart : w_last && ((w_done && !pause) || restart);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_dc    <= '0;
            r_cnt   <= '0;
`ifdef PHASE_SEQ_ONESHOT_EN
            r_done  <= 1'b0;
`endif
        end else if (restart) begin
            r_phase <= '0;
            r_dc    <= '0;
`ifdef PHASE_SEQ_ONESHOT_EN
            r_done  <= 1'b0;
`endif
        end else if (!w_hold) begin
            if (!w_inr) begin
                r_phase <= '0;
                r_dc    <= '0;
            end else if (!pause) begin
                if (!w_done) begin
                    r_dc <= r_dc + 1'b1;
                end else if (!w_last) begin
                    r_phase <= r_phase + 1'b1;
                    r_dc    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
`ifdef PHASE_SEQ_ONESHOT_EN
                    if (oneshot) r_done <= 1'b1;
                    else
`endif
                    begin
                        r_phase <= '0;
                        r_dc    <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: scoreboard bench for phase_sequencer across several NUM_PHASES builds.
module tb_phase_sequencer;
    typedef struct {int ph; int lc;} exp_t;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic p3 = 0, r3 = 0, p4 = 0, r4 = 0, p5 = 0, r5 = 0, p2 = 0, r2 = 0;
    logic os3 = 0, os4 = 0, os5 = 0, os2 = 0;
    logic dn3, dn4, dn5, dn2;
    logic [11:0] d3 = '0;
    logic [15:0] d4 = '0;
    logic [19:0] d5 = '0;
    logic [7:0]  d2 = '0;
    logic [1:0] ph3, ph4;
    logic [2:0] ph5;
    logic [0:0] ph2;
    logic o3, e3, t3, o4, e4, t4, o5, e5, t5, o2, e2, t2;
    logic [7:0] lc3, lc4, lc5;
    logic [1:0] lc2;

    phase_sequencer #(.NUM_PHASES(3)) u3 (.clk(clk), .rst(rst), .pause(p3), .restart(r3),
`ifdef PHASE_SEQ_ONESHOT_EN
        .oneshot(os3), .done(dn3),
`endif
        .dwell(d3), .phase(ph3), .odd(o3), .even(e3), .terminal(t3), .loop_cnt(lc3));
    phase_sequencer #(.NUM_PHASES(4)) u4 (.clk(clk), .rst(rst), .pause(p4), .restart(r4),
`ifdef PHASE_SEQ_ONESHOT_EN
        .oneshot(os4), .done(dn4),
`endif
        .dwell(d4), .phase(ph4), .odd(o4), .even(e4), .terminal(t4), .loop_cnt(lc4));
    phase_sequencer #(.NUM_PHASES(5)) u5 (.clk(clk), .rst(rst), .pause(p5), .restart(r5),
`ifdef PHASE_SEQ_ONESHOT_EN
        .oneshot(os5), .done(dn5),
`endif
        .dwell(d5), .phase(ph5), .odd(o5), .even(e5), .terminal(t5), .loop_cnt(lc5));
    phase_sequencer #(.NUM_PHASES(2), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .pause(p2), .restart(r2),
`ifdef PHASE_SEQ_ONESHOT_EN
        .oneshot(os2), .done(dn2),
`endif
        .dwell(d2), .phase(ph2), .odd(o2), .even(e2), .terminal(t2), .loop_cnt(lc2));

    int pass_cnt = 0, tot = 0;
    int mph, mdc, mlc;
    exp_t q[$];

    task automatic mstep(input int n, input int dw, input int m, input bit p, input bit r, output bit term);
        term = (mph == n - 1) && ((mdc >= dw && !p) || r);
        if (r) begin
            mph = 0; mdc = 0;
        end else if (!p) begin
            if (mdc < dw) mdc++;
            else if (mph < n - 1) begin mph++; mdc = 0; end
            else begin mph = 0; mdc = 0; mlc = (mlc + 1) % m; end
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        mph = 0; mdc = 0; mlc = 0;
        q.delete();
    endtask

    task automatic test_reset;
        do_reset();
        tot++; if (ph3 !== 2'd0) $display("FAIL rst_phase got %0d exp 0", ph3); else pass_cnt++;
        tot++; if (o3 !== 1'b1 || e3 !== 1'b0) $display("FAIL rst_oddeven got %b%b exp 10", o3, e3); else pass_cnt++;
        tot++; if (lc3 !== 8'd0) $display("FAIL rst_loop got %0d exp 0", lc3); else pass_cnt++;
        tot++; if (ph5 !== 3'd0 || lc5 !== 8'd0) $display("FAIL rst_u5 got %0d/%0d exp 0/0", ph5, lc5); else pass_cnt++;
    endtask

    task automatic test_basic;
        exp_t e;
        d3 = '0; p3 = 0; r3 = 0;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            tot++; if (t3 !== ((k - 1) % 3 == 2)) $display("FAIL t1_term k=%0d got %b", k, t3); else pass_cnt++;
            q.push_back('{k % 3, k / 3});
            @(posedge clk); #1;
            e = q.pop_front();
            tot++; if (ph3 !== e.ph) $display("FAIL t1_phase k=%0d got %0d exp %0d", k, ph3, e.ph); else pass_cnt++;
            tot++; if (lc3 !== e.lc) $display("FAIL t1_loop k=%0d got %0d exp %0d", k, lc3, e.lc); else pass_cnt++;
            tot++; if (o3 !== (e.ph % 2 == 0) || e3 !== (e.ph % 2 == 1))
                $display("FAIL t1_oddeven k=%0d got %b%b phase %0d", k, o3, e3, e.ph); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_dwell;
        exp_t e;
        int seq[$];
        int durs[4] = '{2, 3, 1, 4};
        for (int i = 0; i < 4; i++) for (int j = 0; j < durs[i]; j++) seq.push_back(i);
        d4 = {4'd3, 4'd0, 4'd2, 4'd1};
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            tot++; if (t4 !== ((k - 1) % 10 == 9)) $display("FAIL t2_term k=%0d got %b", k, t4); else pass_cnt++;
            q.push_back('{seq[k % 10], k / 10});
            @(posedge clk); #1;
            e = q.pop_front();
            tot++; if (ph4 !== e.ph) $display("FAIL t2_phase k=%0d got %0d exp %0d", k, ph4, e.ph); else pass_cnt++;
            tot++; if (lc4 !== e.lc) $display("FAIL t2_loop k=%0d got %0d exp %0d", k, lc4, e.lc); else pass_cnt++;
            tot++; if (o4 !== (e.ph % 2 == 0) || e4 !== (e.ph % 2 == 1))
                $display("FAIL t2_oddeven k=%0d got %b%b", k, o4, e4); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_pause;
        exp_t e;
        bit term;
        bit [1:0] tab [11] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b11, 2'b00};
        d3 = '0;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            p3 = tab[i][1]; r3 = tab[i][0];
            #1;
            mstep(3, 0, 256, tab[i][1], tab[i][0], term);
            tot++; if (t3 !== term) $display("FAIL t3_term i=%0d got %b exp %b", i, t3, term); else pass_cnt++;
            q.push_back('{mph, mlc});
            @(posedge clk); #1;
            e = q.pop_front();
            tot++; if (ph3 !== e.ph || lc3 !== e.lc)
                $display("FAIL t3_state i=%0d got %0d/%0d exp %0d/%0d", i, ph3, lc3, e.ph, e.lc); else pass_cnt++;
            @(negedge clk);
        end
        p3 = 0; r3 = 0;
    endtask

    task automatic test_dwell_change;
        exp_t e;
        bit term;
        int dw0[5] = '{5, 5, 0, 0, 0};
        d3 = {4'd0, 4'd0, 4'd5};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d3 = {4'd0, 4'd0, 4'(dw0[i])};
            #1;
            mstep(3, (mph == 0) ? dw0[i] : 0, 256, 0, 0, term);
            tot++; if (t3 !== term) $display("FAIL dwchg_term i=%0d got %b exp %b", i, t3, term); else pass_cnt++;
            q.push_back('{mph, mlc});
            @(posedge clk); #1;
            e = q.pop_front();
            tot++; if (ph3 !== e.ph || lc3 !== e.lc)
                $display("FAIL dwchg_state i=%0d got %0d/%0d exp %0d/%0d", i, ph3, lc3, e.ph, e.lc); else pass_cnt++;
            @(negedge clk);
        end
        d3 = '0;
    endtask

    task automatic test_restart;
        exp_t e;
        bit term;
        d5 = {5{4'd2}};
        do_reset();
        for (int i = 0; i < 34; i++) begin
            r5 = (i == 28);
            #1;
            mstep(5, 2, 256, 0, i == 28, term);
            tot++; if (t5 !== term) $display("FAIL t4_term i=%0d got %b exp %b", i, t5, term); else pass_cnt++;
            q.push_back('{mph, mlc});
            @(posedge clk); #1;
            e = q.pop_front();
            tot++; if (ph5 !== e.ph || lc5 !== e.lc)
                $display("FAIL t4_state i=%0d got %0d/%0d exp %0d/%0d", i, ph5, lc5, e.ph, e.lc); else pass_cnt++;
            tot++; if (o5 !== (e.ph % 2 == 0) || e5 !== (e.ph % 2 == 1))
                $display("FAIL t4_oddeven i=%0d got %b%b", i, o5, e5); else pass_cnt++;
            @(negedge clk);
        end
        r5 = 0;
        @(posedge clk); #1;
        tot++; if (ph5 !== 3'd2 || lc5 !== 8'd1) $display("FAIL t4_pre_rst got %0d/%0d exp 2/1", ph5, lc5); else pass_cnt++;
        #2 rst = 1;
        #1;
        tot++; if (ph5 !== 3'd0 || lc5 !== 8'd0) $display("FAIL t4_async_rst got %0d/%0d exp 0/0", ph5, lc5); else pass_cnt++;
        rst = 0;
        mph = 0; mdc = 0; mlc = 0;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        exp_t e;
        bit term;
        d2 = '0;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            mstep(2, 0, 4, 0, 0, term);
            tot++; if (t2 !== term) $display("FAIL t5_term k=%0d got %b exp %b", k, t2, term); else pass_cnt++;
            q.push_back('{mph, mlc});
            @(posedge clk); #1;
            e = q.pop_front();
            tot++; if (ph2 !== e.ph || lc2 !== e.lc)
                $display("FAIL t5_state k=%0d got %0d/%0d exp %0d/%0d", k, ph2, lc2, e.ph, e.lc); else pass_cnt++;
            tot++; if (o2 !== (e.ph == 0) || e2 !== (e.ph == 1)) $display("FAIL t5_oddeven k=%0d got %b%b", k, o2, e2); else pass_cnt++;
            @(negedge clk);
        end
        tot++; if (lc2 !== 2'd1) $display("FAIL t5_wrap got %0d exp 1", lc2); else pass_cnt++;
    endtask

`ifdef PHASE_SEQ_ONESHOT_EN
    task automatic test_oneshot;
        d3 = '0; p3 = 0; r3 = 0; os3 = 1;
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        tot++; if (ph3 !== 2'd2 || dn3 !== 1'b0) $display("FAIL t6_pre got %0d/%b exp 2/0", ph3, dn3); else pass_cnt++;
        @(posedge clk); #1;
        tot++; if (ph3 !== 2'd2 || dn3 !== 1'b1 || lc3 !== 8'd1)
            $display("FAIL t6_done got %0d/%b/%0d exp 2/1/1", ph3, dn3, lc3); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            p3 = i[0];
            #1;
            tot++; if (t3 !== 1'b0) $display("FAIL t6_term i=%0d got %b exp 0", i, t3); else pass_cnt++;
            @(posedge clk); #1;
            tot++; if (ph3 !== 2'd2 || dn3 !== 1'b1 || lc3 !== 8'd1)
                $display("FAIL t6_hold i=%0d got %0d/%b/%0d exp 2/1/1", i, ph3, dn3, lc3); else pass_cnt++;
        end
        @(negedge clk);
        p3 = 0; r3 = 1;
        #1;
        tot++; if (t3 !== 1'b1) $display("FAIL t6_rterm got %b exp 1", t3); else pass_cnt++;
        @(posedge clk); #1;
        tot++; if (ph3 !== 2'd0 || dn3 !== 1'b0 || lc3 !== 8'd1)
            $display("FAIL t6_restart got %0d/%b/%0d exp 0/0/1", ph3, dn3, lc3); else pass_cnt++;
        @(negedge clk);
        r3 = 0; os3 = 0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_dwell();
        test_pause();
        test_dwell_change();
        test_restart();
        test_wrap();
`ifdef PHASE_SEQ_ONESHOT_EN
        test_oneshot();
`endif
        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end
endmodule
